// File: rtl/fir_stream.sv
// Streaming 4-tap FIR filter with a single time-multiplexed multiplier.
// Each accepted sample is followed by one MAC cycle per tap and then the result is offered downstream.
module fir_stream #(
  parameter logic signed [7:0] C0 = 8'sd1,
  parameter logic signed [7:0] C1 = 8'sd0,
  parameter logic signed [7:0] C2 = 8'sd0,
  parameter logic signed [7:0] C3 = 8'sd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [7:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic signed [15:0] out_data,
  input  logic               out_ready,
  input  logic               clear,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_next;

  logic signed [7:0]  x0, x1, x2, x3;
  logic signed [15:0] acc;
  logic [1:0]         tap;
  logic signed [7:0]  tap_x;
  logic signed [7:0]  tap_c;
  logic [15:0]        product;
  logic [15:0]        sum;
  logic               accept;

  always_comb begin
    tap_x = x0;
    tap_c = C0;
    case (tap)
      2'd0: begin tap_x = x0; tap_c = C0; end
      2'd1: begin tap_x = x1; tap_c = C1; end
      2'd2: begin tap_x = x2; tap_c = C2; end
      default: begin tap_x = x3; tap_c = C3; end
    endcase
  end

  // Low 16 bits of the sign-extended product equal the signed product modulo 2^16.
  assign product = {{8{tap_x[7]}}, tap_x} * {{8{tap_c[7]}}, tap_c};
  assign sum     = acc + product;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = rst_n && !clear;
        if (in_valid && in_ready) state_next = MAC;
      end
      MAC: if (tap == 2'd3) state_next = OUT;
      OUT: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
      acc       <= '0;
      tap       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (clear) begin
        x0        <= '0;
        x1        <= '0;
        x2        <= '0;
        x3        <= '0;
        acc       <= '0;
        tap       <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              x3  <= x2;
              x2  <= x1;
              x1  <= x0;
              x0  <= in_data;
              acc <= '0;
              tap <= '0;
            end
          end
          MAC: begin
            acc <= sum;
            tap <= tap + 2'd1;
            if (tap == 2'd3) begin
              out_data  <= sum;
              out_valid <= 1'b1;
            end
          end
          OUT: if (out_ready) out_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_stream.sv
// Directed bench for fir_stream: a vector table for steady streaming plus hand-written
// sequences for backpressure, clear and reset corner cases.
module tb_fir_stream;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [7:0]  in_data;
  logic               out_ready;
  logic               clear;

  logic               in_ready1, out_valid1, busy1;
  logic signed [15:0] out_data1;
  logic               in_ready2, out_valid2, busy2;
  logic signed [15:0] out_data2;

  logic               use_wide;
  logic               in_ready_s, out_valid_s, busy_s;
  logic signed [15:0] out_data_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_stream #(.C0(8'sd1), .C1(8'sd2), .C2(8'sd3), .C3(8'sd4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_ready(out_ready), .clear(clear), .busy(busy1)
  );

  fir_stream #(.C0(8'sd127), .C1(8'sd127), .C2(8'sd127), .C3(8'sd127)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
    .out_ready(out_ready), .clear(clear), .busy(busy2)
  );

  assign in_ready_s  = use_wide ? in_ready2  : in_ready1;
  assign out_valid_s = use_wide ? out_valid2 : out_valid1;
  assign out_data_s  = use_wide ? out_data2  : out_data1;
  assign busy_s      = use_wide ? busy2      : busy1;

  typedef struct {
    logic               rst_first;
    logic               wide;
    logic signed [7:0]  sample;
    logic signed [15:0] expected;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers one sample, then waits (bounded) for the result and reports data and latency.
  task automatic applyStimulus(input logic signed [7:0] s, output int lat,
                               output logic signed [15:0] data);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = s;
    checkOutput("in_ready before accept", in_ready_s, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_s && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data = out_data_s;
  endtask

  initial begin
    int lat;
    logic signed [15:0] data;
    logic signed [15:0] held;
    int seen;

    vecs[0]  = '{1'b1, 1'b0, 8'sd1,    16'sd1};
    vecs[1]  = '{1'b0, 1'b0, 8'sd0,    16'sd2};
    vecs[2]  = '{1'b0, 1'b0, 8'sd0,    16'sd3};
    vecs[3]  = '{1'b0, 1'b0, 8'sd0,    16'sd4};
    vecs[4]  = '{1'b1, 1'b0, -8'sd128, -16'sd128};
    vecs[5]  = '{1'b0, 1'b0, -8'sd128, -16'sd384};
    vecs[6]  = '{1'b0, 1'b0, -8'sd128, -16'sd768};
    vecs[7]  = '{1'b0, 1'b0, -8'sd128, -16'sd1280};
    vecs[8]  = '{1'b1, 1'b0, 8'sd3,    16'sd3};
    vecs[9]  = '{1'b0, 1'b0, -8'sd2,   16'sd4};
    vecs[10] = '{1'b0, 1'b0, 8'sd5,    16'sd10};
    vecs[11] = '{1'b0, 1'b0, -8'sd1,   16'sd15};
    vecs[12] = '{1'b1, 1'b1, 8'sd127,  16'sd16129};
    vecs[13] = '{1'b0, 1'b1, 8'sd127,  16'sd32258};
    vecs[14] = '{1'b0, 1'b1, 8'sd127,  -16'sd17149};
    vecs[15] = '{1'b0, 1'b1, 8'sd127,  -16'sd1020};

    use_wide  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", in_ready_s, 0);
    checkOutput("reset out_valid", out_valid_s, 0);
    checkOutput("reset busy", busy_s, 0);
    checkOutput("reset out_data", out_data_s, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", in_ready_s, 1);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst_first) doReset();
      use_wide = vecs[i].wide;
      applyStimulus(vecs[i].sample, lat, data);
      checkOutput($sformatf("vec%0d data", i), data, vecs[i].expected);
      checkOutput($sformatf("vec%0d latency", i), lat, 4);
    end
    use_wide = 1'b0;

    // Backpressure: result held for 10 cycles while a competing sample is offered.
    doReset();
    out_ready = 1'b0;
    applyStimulus(8'sd10, lat, data);
    checkOutput("bp data", data, 10);
    held     = out_data_s;
    in_valid = 1'b1;
    in_data  = 8'sd99;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp out_valid c%0d", c), out_valid_s, 1);
      checkOutput($sformatf("bp out_data c%0d", c), out_data_s, held);
      checkOutput($sformatf("bp in_ready c%0d", c), in_ready_s, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp release out_valid", out_valid_s, 0);
    checkOutput("bp release busy", busy_s, 0);
    checkOutput("bp release in_ready", in_ready_s, 1);
    applyStimulus(8'sd1, lat, data);
    checkOutput("bp follow-up data", data, 21);

    // Clear during MAC after history 5,6 and in-flight 7.
    doReset();
    applyStimulus(8'sd5, lat, data);
    checkOutput("clr first data", data, 5);
    applyStimulus(8'sd6, lat, data);
    checkOutput("clr second data", data, 16);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'sd7;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("clr busy in MAC", busy_s, 1);
    clear = 1'b1;
    #1;
    checkOutput("clr in_ready gated", in_ready_s, 0);
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clr busy after", busy_s, 0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid_s) seen++;
      @(negedge clk);
    end
    checkOutput("clr no out_valid", seen, 0);
    applyStimulus(8'sd1, lat, data);
    checkOutput("clr next data", data, 1);

    // Reset while a result waits in OUT.
    doReset();
    out_ready = 1'b0;
    applyStimulus(8'sd9, lat, data);
    checkOutput("rst-out data", data, 9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst-out in_ready low", in_ready_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst-out out_valid", out_valid_s, 0);
    checkOutput("rst-out busy", busy_s, 0);
    out_ready = 1'b1;
    applyStimulus(8'sd2, lat, data);
    checkOutput("rst-out next data", data, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
